// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the MEM-stage load/store unit.
package mem_access_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    // Access sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Loads accept all five widths; stores only the signed-named three
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = is_load;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores, lane extraction and
// sign/zero extension for loads, and misalignment detection.
// Build option: MEM_MISALIGN_TRAP_EN reports misaligned halfword/word accesses;
// without it the lane is rounded down to the natural boundary and misalign is 0.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic              misalign
);

    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Effective byte lane and misalignment flag for the access size
    always_comb begin
        misalign = 1'b0;
        lane     = addr_lo;
        case (funct3)
            F3_H, F3_HU: begin
`ifdef MEM_MISALIGN_TRAP_EN
                misalign = addr_lo[0];
`else
                lane = {addr_lo[1], 1'b0};
`endif
            end
            F3_W: begin
`ifdef MEM_MISALIGN_TRAP_EN
                misalign = |addr_lo;
`else
                lane = 2'b00;
`endif
            end
            default: ;
        endcase
    end

    // Byte enables and lane-replicated write data; funct3[1:0] is the size
    always_comb begin
        be    = '0;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = BE_W'(4'b0001 << lane);
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    // Pick the addressed byte/half and extend it to a full word
    always_comb begin
        ld_byte   = rdata[{lane, 3'b000} +: 8];
        ld_half   = lane[1] ? rdata[31:16] : rdata[15:0];
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_data = {24'd0, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_data = {16'd0, ld_half};
            F3_W:    load_data = rdata;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit. Turns the EX/MEM access into a
// word-aligned byte-enabled request on a ready-handshaked data port, stalls the
// pipeline until it completes and returns the extended load result.
// Build option: MEM_MISALIGN_TRAP_EN (misaligned ops go straight to DONE with
// Misalign=1 and no bus access; see mem_lane_align).
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Ex_In_Mem_Valid,
    input  logic              Ex_In_Mem_MemRead,
    input  logic              Ex_In_Mem_MemWrite,
    input  logic [2:0]        Ex_In_Mem_Funct3,
    input  logic [ADDR_W-1:0] Ex_In_Mem_Addr,
    input  logic [DATA_W-1:0] Ex_In_Mem_Store_Data,
    output logic              Dmem_Req,
    output logic              Dmem_We,
    output logic [ADDR_W-1:0] Dmem_Addr,
    output logic [DATA_W-1:0] Dmem_Wdata,
    output logic [BE_W-1:0]   Dmem_Be,
    input  logic              Dmem_Ready,
    input  logic [DATA_W-1:0] Dmem_Rdata,
    output logic              Mem_Stall,
    output logic [DATA_W-1:0] Mem_Out_Load_Data,
    output logic              Mem_Out_Misalign
);

    mem_state_e        state;
    mem_state_e        state_next;

    logic              mem_op_c;
    logic              in_idle_c;
    logic [2:0]        req_f3;
    logic [1:0]        req_lo;
    logic              req_load;
    logic [2:0]        align_f3_c;
    logic [1:0]        align_lo_c;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] load_c;
    logic              misalign_c;

    // A real memory op; MemRead wins when both strobes are set
    assign mem_op_c = Ex_In_Mem_Valid
                    & (Ex_In_Mem_MemRead | Ex_In_Mem_MemWrite)
                    & f3_legal(Ex_In_Mem_MemRead, Ex_In_Mem_Funct3);

    // Steer from live inputs while idle, from the latched request afterwards
    assign in_idle_c  = (state == IDLE);
    assign align_f3_c = in_idle_c ? Ex_In_Mem_Funct3    : req_f3;
    assign align_lo_c = in_idle_c ? Ex_In_Mem_Addr[1:0] : req_lo;

    mem_lane_align u_lane_align (
        .funct3     (align_f3_c),
        .addr_lo    (align_lo_c),
        .store_data (Ex_In_Mem_Store_Data),
        .rdata      (Dmem_Rdata),
        .be         (be_c),
        .wdata      (wdata_c),
        .load_data  (load_c),
        .misalign   (misalign_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and stall; stall is same-cycle so the op in IDLE holds EX/MEM
    always_comb begin
        state_next = state;
        Mem_Stall  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op_c) begin
                    Mem_Stall  = 1'b1;
                    state_next = misalign_c ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                Mem_Stall = 1'b1;
                if (Dmem_Ready) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (reset) begin
            Mem_Stall = 1'b0;
        end
    end

    // Bus request, latched access attributes and MEM/WB result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            Dmem_Req          <= 1'b0;
            Dmem_We           <= 1'b0;
            Dmem_Addr         <= '0;
            Dmem_Wdata        <= '0;
            Dmem_Be           <= '0;
            Mem_Out_Load_Data <= '0;
            Mem_Out_Misalign  <= 1'b0;
            req_f3            <= '0;
            req_lo            <= '0;
            req_load          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op_c) begin
                        if (misalign_c) begin
                            Mem_Out_Misalign  <= 1'b1;
                            Mem_Out_Load_Data <= '0;
                        end else begin
                            Dmem_Req   <= 1'b1;
                            Dmem_We    <= ~Ex_In_Mem_MemRead;
                            Dmem_Addr  <= {Ex_In_Mem_Addr[ADDR_W-1:2], 2'b00};
                            Dmem_Wdata <= wdata_c;
                            Dmem_Be    <= be_c;
                            req_f3     <= Ex_In_Mem_Funct3;
                            req_lo     <= Ex_In_Mem_Addr[1:0];
                            req_load   <= Ex_In_Mem_MemRead;
                        end
                    end
                end
                ACCESS: begin
                    if (Dmem_Ready) begin
                        Dmem_Req          <= 1'b0;
                        Mem_Out_Load_Data <= req_load ? load_c : '0;
                        Mem_Out_Misalign  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit with a
// byte-lane memory model and a randomized op stream.
module tb_mem_access_unit;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        int          stall;
        int          req;
        bit          done;
        bit          stable;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        mis;
        logic        req_done;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_rd, ex_wr;
    logic [2:0]  ex_f3;
    logic [31:0] ex_addr, ex_sd;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall;
    logic [31:0] ld_out;
    logic        mis_out;

    int n_cmp = 0;
    int n_bad = 0;

    bit [31:0] bus_mem [0:4095];
    bit [31:0] ref_mem [0:4095];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .Ex_In_Mem_Valid      (ex_valid),
        .Ex_In_Mem_MemRead    (ex_rd),
        .Ex_In_Mem_MemWrite   (ex_wr),
        .Ex_In_Mem_Funct3     (ex_f3),
        .Ex_In_Mem_Addr       (ex_addr),
        .Ex_In_Mem_Store_Data (ex_sd),
        .Dmem_Req             (dmem_req),
        .Dmem_We              (dmem_we),
        .Dmem_Addr            (dmem_addr),
        .Dmem_Wdata           (dmem_wdata),
        .Dmem_Be              (dmem_be),
        .Dmem_Ready           (dmem_ready),
        .Dmem_Rdata           (dmem_rdata),
        .Mem_Stall            (mem_stall),
        .Mem_Out_Load_Data    (ld_out),
        .Mem_Out_Misalign     (mis_out)
    );

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == F3_W) return 4;
        if (f3 == F3_H || f3 == F3_HU) return 2;
        return 1;
    endfunction

    function automatic bit legal(input logic rd, input logic [2:0] f3);
        if (f3 == F3_B || f3 == F3_H || f3 == F3_W) return 1'b1;
        return rd && (f3 == F3_BU || f3 == F3_HU);
    endfunction

    // Expected load value from a memory word, by arithmetic on the byte offset
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int lane,
                                             input logic [31:0] word);
        int n;
        logic [31:0] raw;
        n = size_of(f3);
        if (n == 4) return word;
        raw = (word >> (8 * lane)) & ((32'd1 << (8 * n)) - 32'd1);
        if ((f3 == F3_B || f3 == F3_H) && raw >= (32'd1 << (8 * n - 1)))
            raw = raw - (32'd1 << (8 * n));
        return raw;
    endfunction

    // Present one memory op, act as the memory with Ready after k Req cycles,
    // and collect what the DUT did up to and including its DONE cycle.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input int k, output obs_t o);
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        o.stall = 0; o.req = 0; o.done = 1'b0; o.stable = 1'b1;
        o.addr = '0; o.we = 1'b0; o.be = '0; o.wdata = '0;
        o.ld = '0; o.mis = 1'b0; o.req_done = 1'b0;
        a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
        ex_valid = 1'b1; ex_rd = rd; ex_wr = wr; ex_f3 = f3;
        ex_addr = addr; ex_sd = sd; dmem_ready = 1'b0;
        #1;
        for (int c = 0; c < 200; c++) begin
            if (!mem_stall) begin
                o.done = (c > 0);
                break;
            end
            o.stall++;
            if (dmem_req) begin
                o.req++;
                if (o.req == 1) begin
                    a0 = dmem_addr; w0 = dmem_wdata; b0 = dmem_be; we0 = dmem_we;
                end else if (dmem_addr !== a0 || dmem_wdata !== w0 ||
                             dmem_be !== b0 || dmem_we !== we0) begin
                    o.stable = 1'b0;
                end
                if (o.req == k) begin
                    o.addr = dmem_addr; o.we = dmem_we; o.be = dmem_be; o.wdata = dmem_wdata;
                    dmem_rdata = bus_mem[idx_of(dmem_addr)];
                    if (dmem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (dmem_be[i]) bus_mem[idx_of(dmem_addr)][8*i +: 8] = dmem_wdata[8*i +: 8];
                    end
                    dmem_ready = 1'b1;
                end
            end
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
        end
        o.ld = ld_out; o.mis = mis_out; o.req_done = dmem_req;
        ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0;
        if (!o.done) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0; ex_f3 = F3_W;
        ex_addr = '0; ex_sd = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
        n_cmp++; if (dmem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b expected 0", dmem_we); end
        n_cmp++; if (dmem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", dmem_addr); end
        n_cmp++; if (dmem_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata: got %h expected 0", dmem_wdata); end
        n_cmp++; if (dmem_be !== 4'd0) begin n_bad++; $display("FAIL reset_be: got %b expected 0", dmem_be); end
        n_cmp++; if (ld_out !== 32'd0) begin n_bad++; $display("FAIL reset_ld: got %h expected 0", ld_out); end
        n_cmp++; if (mis_out !== 1'b0) begin n_bad++; $display("FAIL reset_mis: got %b expected 0", mis_out); end
        ex_valid = 1'b1; ex_rd = 1'b1;
        #1;
        n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
        ex_valid = 1'b0; ex_rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_no_mem_op();
        logic [2:0] f3s [4];
        logic       rds [4];
        logic       vs  [4];
        f3s[0] = 3'b000; rds[0] = 1'b0; vs[0] = 1'b1;  // ALU op, no strobes
        f3s[1] = F3_W;   rds[1] = 1'b1; vs[1] = 1'b0;  // bubble
        f3s[2] = 3'b011; rds[2] = 1'b1; vs[2] = 1'b1;  // illegal load width
        f3s[3] = F3_BU;  rds[3] = 1'b0; vs[3] = 1'b1;  // illegal store width
        for (int t = 0; t < 4; t++) begin
            ex_valid = vs[t]; ex_f3 = f3s[t]; ex_addr = 32'h0000_1000;
            ex_rd = (t == 0) ? 1'b0 : rds[t];
            ex_wr = (t == 0) ? 1'b0 : ~rds[t];
            for (int c = 0; c < 3; c++) begin
                #1;
                n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL nomem_stall[%0d]: got %b expected 0", t, mem_stall); end
                n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL nomem_req[%0d]: got %b expected 0", t, dmem_req); end
                @(posedge clk); #1;
            end
        end
        ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0;
    endtask

    task automatic test_sb();
        obs_t o;
        run_op(1'b0, 1'b1, F3_B, 32'h0000_1003, 32'h0000_00A5, 3, o);
        n_cmp++; if (o.done !== 1'b1) begin n_bad++; $display("FAIL sb_done: got %b expected 1", o.done); end
        n_cmp++; if (o.addr !== 32'h0000_1000) begin n_bad++; $display("FAIL sb_addr: got %h expected 00001000", o.addr); end
        n_cmp++; if (o.be !== 4'b1000) begin n_bad++; $display("FAIL sb_be: got %b expected 1000", o.be); end
        n_cmp++; if (o.wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", o.wdata); end
        n_cmp++; if (o.we !== 1'b1) begin n_bad++; $display("FAIL sb_we: got %b expected 1", o.we); end
        n_cmp++; if (o.stall != 4) begin n_bad++; $display("FAIL sb_stall_cycles: got %0d expected 4", o.stall); end
        n_cmp++; if (o.ld !== 32'd0) begin n_bad++; $display("FAIL sb_ld: got %h expected 0", o.ld); end
        n_cmp++; if (o.req_done !== 1'b0) begin n_bad++; $display("FAIL sb_req_done: got %b expected 0", o.req_done); end
        ref_mem[idx_of(32'h1000)][31:24] = 8'hA5;
    endtask

    task automatic test_loads();
        obs_t o;
        logic [31:0] a [3];
        logic [2:0]  f [3];
        logic [31:0] e [3];
        bus_mem[idx_of(32'h2000)] = 32'h80FF_7F01;
        ref_mem[idx_of(32'h2000)] = 32'h80FF_7F01;
        a[0] = 32'h2001; f[0] = F3_B;  e[0] = 32'h0000_007F;
        a[1] = 32'h2003; f[1] = F3_BU; e[1] = 32'h0000_0080;
        a[2] = 32'h2002; f[2] = F3_H;  e[2] = 32'hFFFF_80FF;
        for (int t = 0; t < 3; t++) begin
            run_op(1'b1, 1'b0, f[t], a[t], 32'd0, 1, o);
            n_cmp++; if (o.ld !== e[t]) begin n_bad++; $display("FAIL load_data[%0d]: got %h expected %h", t, o.ld, e[t]); end
            n_cmp++; if (o.stall != 2) begin n_bad++; $display("FAIL load_stall[%0d]: got %0d expected 2", t, o.stall); end
            n_cmp++; if (o.addr !== 32'h0000_2000) begin n_bad++; $display("FAIL load_addr[%0d]: got %h expected 00002000", t, o.addr); end
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        bus_mem[idx_of(32'h3000)] = 32'h1234_5678;
        ref_mem[idx_of(32'h3000)] = 32'h1234_5678;
        run_op(1'b1, 1'b0, F3_W, 32'h0000_3002, 32'd0, 2, o);
        n_cmp++; if (o.done !== 1'b1) begin n_bad++; $display("FAIL mis_lw_done: got %b expected 1", o.done); end
`ifdef MEM_MISALIGN_TRAP_EN
        n_cmp++; if (o.req != 0) begin n_bad++; $display("FAIL mis_lw_req: got %0d expected 0", o.req); end
        n_cmp++; if (o.mis !== 1'b1) begin n_bad++; $display("FAIL mis_lw_flag: got %b expected 1", o.mis); end
        n_cmp++; if (o.ld !== 32'd0) begin n_bad++; $display("FAIL mis_lw_ld: got %h expected 0", o.ld); end
        n_cmp++; if (o.stall != 1) begin n_bad++; $display("FAIL mis_lw_stall: got %0d expected 1", o.stall); end
`else
        n_cmp++; if (o.addr !== 32'h0000_3000) begin n_bad++; $display("FAIL mis_lw_addr: got %h expected 00003000", o.addr); end
        n_cmp++; if (o.ld !== 32'h1234_5678) begin n_bad++; $display("FAIL mis_lw_ld: got %h expected 12345678", o.ld); end
        n_cmp++; if (o.mis !== 1'b0) begin n_bad++; $display("FAIL mis_lw_flag: got %b expected 0", o.mis); end
        n_cmp++; if (o.stall != 3) begin n_bad++; $display("FAIL mis_lw_stall: got %0d expected 3", o.stall); end
`endif
        run_op(1'b0, 1'b1, F3_H, 32'h0000_3001, 32'h0000_BEEF, 1, o);
`ifdef MEM_MISALIGN_TRAP_EN
        n_cmp++; if (o.req != 0) begin n_bad++; $display("FAIL mis_sh_req: got %0d expected 0", o.req); end
        n_cmp++; if (o.mis !== 1'b1) begin n_bad++; $display("FAIL mis_sh_flag: got %b expected 1", o.mis); end
        n_cmp++; if (bus_mem[idx_of(32'h3000)] !== 32'h1234_5678) begin n_bad++; $display("FAIL mis_sh_suppress: got %h expected 12345678", bus_mem[idx_of(32'h3000)]); end
`else
        n_cmp++; if (o.be !== 4'b0011) begin n_bad++; $display("FAIL mis_sh_be: got %b expected 0011", o.be); end
        n_cmp++; if (o.wdata !== 32'hBEEF_BEEF) begin n_bad++; $display("FAIL mis_sh_wdata: got %h expected beefbeef", o.wdata); end
        ref_mem[idx_of(32'h3000)][15:0] = 16'hBEEF;
`endif
    endtask

    task automatic test_reset_during_access();
        obs_t o;
        ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b0; ex_f3 = F3_W;
        ex_addr = 32'h0000_6000; dmem_ready = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL rst_acc_req_up: got %b expected 1", dmem_req); end
        @(posedge clk); #1;
        reset = 1'b1; ex_valid = 1'b0; ex_rd = 1'b0;
        #1;
        n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL rst_acc_stall_forced: got %b expected 0", mem_stall); end
        @(posedge clk); #1;
        n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL rst_acc_req_drop: got %b expected 0", dmem_req); end
        reset = 1'b0;
        @(posedge clk); #1;
        dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL rst_late_ready_stall: got %b expected 0", mem_stall); end
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL rst_late_ready_req: got %b expected 0", dmem_req); end
        n_cmp++; if (ld_out !== 32'd0) begin n_bad++; $display("FAIL rst_late_ready_ld: got %h expected 0", ld_out); end
        bus_mem[idx_of(32'h6000)] = 32'hCAFE_F00D;
        ref_mem[idx_of(32'h6000)] = 32'hCAFE_F00D;
        run_op(1'b1, 1'b0, F3_W, 32'h0000_6000, 32'd0, 2, o);
        n_cmp++; if (o.ld !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL rst_recover_ld: got %h expected cafef00d", o.ld); end
        n_cmp++; if (o.stall != 3) begin n_bad++; $display("FAIL rst_recover_stall: got %0d expected 3", o.stall); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [31:0] v;
        v = $urandom;
        run_op(1'b0, 1'b1, F3_W, 32'h0000_5008, v, 2, o);
        n_cmp++; if (o.be !== 4'b1111) begin n_bad++; $display("FAIL b2b_sw_be: got %b expected 1111", o.be); end
        n_cmp++; if (o.wdata !== v) begin n_bad++; $display("FAIL b2b_sw_wdata: got %h expected %h", o.wdata, v); end
        ref_mem[idx_of(32'h5008)] = v;
        run_op(1'b1, 1'b0, F3_W, 32'h0000_5008, 32'd0, 1, o);
        n_cmp++; if (o.stall != 2) begin n_bad++; $display("FAIL b2b_lw_stall: got %0d expected 2", o.stall); end
        n_cmp++; if (o.we !== 1'b0) begin n_bad++; $display("FAIL b2b_lw_we: got %b expected 0", o.we); end
        n_cmp++; if (o.ld !== v) begin n_bad++; $display("FAIL b2b_lw_ld: got %h expected %h", o.ld, v); end
    endtask

    task automatic test_random();
        obs_t o;
        for (int t = 0; t < 80; t++) begin
            logic        v, rd, wr;
            logic [2:0]  f3;
            logic [31:0] addr, sd, wexp, lexp;
            logic [3:0]  bexp;
            int          k, n, off, lane, ix;
            bit          mis;
            v    = ($urandom_range(0, 7) != 0);
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 32'h0000_4000 + 32'($urandom_range(0, 31));
            sd   = $urandom;
            k    = $urandom_range(1, 4);
            if (v && (rd || wr) && legal(rd, f3)) begin
                n    = size_of(f3);
                off  = int'(addr % 32'(n));
                mis  = (off != 0);
                lane = int'((addr - 32'(off)) % 32'd4);
                ix   = idx_of(addr);
                run_op(rd, wr, f3, addr, sd, k, o);
                n_cmp++; if (o.done !== 1'b1) begin n_bad++; $display("FAIL rnd_done[%0d]: got %b expected 1", t, o.done); end
                n_cmp++; if (o.req_done !== 1'b0) begin n_bad++; $display("FAIL rnd_req_done[%0d]: got %b expected 0", t, o.req_done); end
                if (TRAP && mis) begin
                    n_cmp++; if (o.stall != 1 || o.req != 0) begin n_bad++; $display("FAIL rnd_trap_cycles[%0d]: got stall %0d req %0d expected 1/0", t, o.stall, o.req); end
                    n_cmp++; if (o.mis !== 1'b1 || o.ld !== 32'd0) begin n_bad++; $display("FAIL rnd_trap_out[%0d]: got mis %b ld %h expected 1/0", t, o.mis, o.ld); end
                end else begin
                    n_cmp++; if (o.stall != k + 1 || o.req != k) begin n_bad++; $display("FAIL rnd_cycles[%0d]: got stall %0d req %0d expected %0d/%0d", t, o.stall, o.req, k + 1, k); end
                    n_cmp++; if (o.addr !== addr - (addr % 32'd4) || o.we !== ~rd || !o.stable) begin n_bad++; $display("FAIL rnd_bus[%0d]: got addr %h we %b stable %0d expected %h/%b/1", t, o.addr, o.we, o.stable, addr - (addr % 32'd4), ~rd); end
                    if (rd) begin
                        lexp = exp_load(f3, lane, ref_mem[ix]);
                    end else begin
                        lexp = 32'd0;
                        bexp = 4'(((1 << n) - 1) << lane);
                        for (int i = 0; i < 4; i++) wexp[8*i +: 8] = sd[8*(i % n) +: 8];
                        for (int i = 0; i < n; i++) ref_mem[ix][8*(lane + i) +: 8] = sd[8*i +: 8];
                        n_cmp++; if (o.be !== bexp || o.wdata !== wexp) begin n_bad++; $display("FAIL rnd_store[%0d]: got be %b wdata %h expected %b/%h", t, o.be, o.wdata, bexp, wexp); end
                    end
                    n_cmp++; if (o.ld !== lexp || o.mis !== 1'b0) begin n_bad++; $display("FAIL rnd_result[%0d]: got ld %h mis %b expected %h/0", t, o.ld, o.mis, lexp); end
                end
            end else begin
                ex_valid = v; ex_rd = rd; ex_wr = wr; ex_f3 = f3; ex_addr = addr; ex_sd = sd;
                #1;
                n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL rnd_nomem_stall[%0d]: got %b expected 0", t, mem_stall); end
                @(posedge clk); #1;
                n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL rnd_nomem_req[%0d]: got %b expected 0", t, dmem_req); end
                ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_no_mem_op();
        test_sb();
        test_loads();
        test_misalign();
        test_reset_during_access();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
